// File: rtl/lzs_pkg.sv
// rtl/lzs_pkg.sv - shared widths, FSM encoding and width clamp for the token packer
package lzs_pkg;

    localparam int OUT_W  = 64;
    localparam int TOK_W  = 13;
    localparam int WID_W  = 4;
    localparam int BCNT_W = 6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // widths above the token maximum are treated as the maximum
    function automatic logic [WID_W-1:0] clamp_width(input logic [WID_W-1:0] w);
        return (w > WID_W'(TOK_W)) ? WID_W'(TOK_W) : w;
    endfunction

endpackage

// File: rtl/encode_shift.sv
// rtl/encode_shift.sv - combinational merge of a right-aligned token behind the accumulator bits
module encode_shift #(
    parameter int OUT_W = 64,
    parameter int TOK_W = 13
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [5:0]       bcnt,
    input  logic [TOK_W-1:0] tok,
    input  logic [3:0]       width,
    output logic [OUT_W-1:0] hi,
    output logic [OUT_W-1:0] lo,
    output logic [6:0]       total
);

    logic [TOK_W-1:0]   tok_m;
    logic [7:0]         sh;
    logic [2*OUT_W-1:0] placed;
    logic [2*OUT_W-1:0] merged;

    // mask the token to its width, then drop it just behind the last valid accumulator bit;
    // hi is the first 64 bits of the stream, lo holds any overflow, MSB-aligned
    always_comb begin
        tok_m  = tok & ((TOK_W'(1) << width) - TOK_W'(1));
        total  = {1'b0, bcnt} + {3'b000, width};
        sh     = 8'd128 - {1'b0, total};
        placed = {{(2*OUT_W-TOK_W){1'b0}}, tok_m} << sh;
        merged = {acc, {OUT_W{1'b0}}} | placed;
        hi     = merged[2*OUT_W-1:OUT_W];
        lo     = merged[OUT_W-1:0];
    end

endmodule

// File: rtl/encode_out.sv
// rtl/encode_out.sv - packs variable-width tokens MSB-first into 64-bit words; ENCODE_OUT_STAT_EN adds out_bits counter
module encode_out #(
    parameter int OUT_W = lzs_pkg::OUT_W,
    parameter int TOK_W = lzs_pkg::TOK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TOK_W-1:0] token_data,
    input  logic [3:0]       token_width,
    input  logic             token_valid,
    input  logic             token_last,
    output logic             token_ack,
    input  logic             fo_full,
    output logic [OUT_W-1:0] fo_data,
    output logic             fo_wen,
    output logic             done_o
`ifdef ENCODE_OUT_STAT_EN
    ,
    output logic [31:0]      out_bits
`endif
);

    import lzs_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [OUT_W-1:0] acc;
    logic [5:0]       bcnt;
    logic             pend;
    logic [3:0]       width_c;
    logic [OUT_W-1:0] m_hi;
    logic [OUT_W-1:0] m_lo;
    logic [6:0]       total;
    logic             in_run;
    logic             accept;
    logic             out_free;
    logic             load_flush;
    logic             load;

    assign width_c    = clamp_width(token_width);
    assign out_free   = !pend || !fo_full;
    assign fo_wen     = pend && !fo_full;
    assign token_ack  = rst && token_valid && in_run && out_free;
    assign accept     = token_ack;
    assign load_flush = (state == ST_FLUSH) && out_free && (bcnt != 6'd0);
    assign load       = (accept && total[6]) || load_flush;

    encode_shift #(
        .OUT_W (OUT_W),
        .TOK_W (TOK_W)
    ) u_shift (
        .acc   (acc),
        .bcnt  (bcnt),
        .tok   (token_data),
        .width (width_c),
        .hi    (m_hi),
        .lo    (m_lo),
        .total (total)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: flush waits for a free output slot, drain ends once the last word leaves
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (accept && token_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (out_free)             state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_free)             state_nxt = ST_DONE;
            ST_DONE:                            state_nxt = ST_RUN;
            default:                            state_nxt = ST_RUN;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        in_run = (state == ST_RUN);
        done_o = (state == ST_DONE);
    end

    // accumulator, output word and pending flag; a drain and a reload may share one edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            bcnt    <= '0;
            pend    <= 1'b0;
            fo_data <= '0;
        end else begin
            if (accept) begin
                bcnt <= total[5:0];
                if (total[6]) begin
                    fo_data <= m_hi;
                    acc     <= m_lo;
                end else begin
                    acc <= m_hi;
                end
            end else if (load_flush) begin
                fo_data <= acc;
                acc     <= '0;
                bcnt    <= '0;
            end else if (done_o) begin
                acc  <= '0;
                bcnt <= '0;
            end
            pend <= load || (pend && !fo_wen);
        end
    end

`ifdef ENCODE_OUT_STAT_EN
    // running count of accepted token bits for the current stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_bits <= '0;
        end else if (done_o) begin
            out_bits <= '0;
        end else if (accept) begin
            out_bits <= out_bits + {28'd0, width_c};
        end
    end
`endif

endmodule

// File: tb/tb_encode_out.sv
// tb/tb_encode_out.sv - scoreboard bench for encode_out with directed token streams
module tb_encode_out;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] token_data;
    logic [3:0]  token_width;
    logic        token_valid;
    logic        token_last;
    logic        token_ack;
    logic        fo_full;
    logic [63:0] fo_data;
    logic        fo_wen;
    logic        done_o;
`ifdef ENCODE_OUT_STAT_EN
    logic [31:0] out_bits;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    int exp_done  = 0;
    int done_seen = 0;
    int cyc = 0;
    int last_wen_cyc = 0;
    bit check_gap = 1'b0;

    always #5 clk = ~clk;

    encode_out u_dut (
        .clk         (clk),
        .rst         (rst),
        .token_data  (token_data),
        .token_width (token_width),
        .token_valid (token_valid),
        .token_last  (token_last),
        .token_ack   (token_ack),
        .fo_full     (fo_full),
        .fo_data     (fo_data),
        .fo_wen      (fo_wen),
        .done_o      (done_o)
`ifdef ENCODE_OUT_STAT_EN
        ,
        .out_bits    (out_bits)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pop and compare every written word, track done pulses
    always @(negedge clk) begin
        if (rst && fo_wen) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL word_unexpected: got %h, required no write", fo_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (fo_data !== e) begin
                    fails++;
                    $display("FAIL word: got %h, required %h", fo_data, e);
                end
            end
            last_wen_cyc = cyc;
        end
        if (rst && done_o) begin
            done_seen++;
            if (check_gap) begin
                tests++;
                if (cyc - last_wen_cyc != 1) begin
                    fails++;
                    $display("FAIL done_gap: got %0d cycles after fo_wen, required 1", cyc - last_wen_cyc);
                end
                check_gap = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [12:0] d, input logic [3:0] w, input logic l);
        bit got;
        got = 1'b0;
        token_data  = d;
        token_width = w;
        token_last  = l;
        token_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (token_ack) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        token_valid = 1'b0;
        token_last  = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no token_ack, required ack within 200 cycles");
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_seen == exp_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (!ok || exp_q.size() != 0 || done_seen != exp_done) begin
            fails++;
            $display("FAIL %s_idle: got %0d words left and %0d done, required 0 left and %0d done",
                     name, exp_q.size(), done_seen, exp_done);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        token_data  = '0;
        token_width = '0;
        token_valid = 1'b1;
        token_last  = 1'b0;
        fo_full     = 1'b0;

        // reset state, with a token offered
        repeat (2) @(negedge clk);
        check("rst_ack",  {63'd0, token_ack}, 64'd0);
        check("rst_wen",  {63'd0, fo_wen},    64'd0);
        check("rst_done", {63'd0, done_o},    64'd0);
        check("rst_data", fo_data,            64'd0);
        token_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 64 single-bit ones
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 64; i++) send(13'h0001, 4'd1, 1'b0);
        wait_idle("ones");

        // five 13-bit tokens, then flush the single residual zero with a width-0 last
        exp_q.push_back(64'hD5E6_AF35_79AB_CD5E);
        exp_q.push_back(64'h0000_0000_0000_0000);
        exp_done++;
        for (int i = 0; i < 5; i++) send(13'h1ABC, 4'd13, 1'b0);
        send(13'h1FFF, 4'd0, 1'b1);
        wait_idle("w13");

        // three 9-bit tokens, last on the third
        exp_q.push_back(64'h7FE0_0000_0000_0000);
        exp_done++;
        check_gap = 1'b1;
        send(13'h00FF, 4'd9, 1'b0);
        send(13'h0180, 4'd9, 1'b0);
        send(13'h0000, 4'd9, 1'b1);
        wait_idle("w9");

        // width clamp and zero-width no-op
        exp_q.push_back(64'hFFF8_003F_FE00_0000);
        exp_done++;
        send(13'h1FFF, 4'd15, 1'b0);
        send(13'h1FFF, 4'd0,  1'b0);
        send(13'h0000, 4'd14, 1'b0);
        send(13'h1FFF, 4'd13, 1'b1);
        wait_idle("clamp");

        // exact 64-bit fill ending on the last token
        exp_q.push_back(64'hFFFF_FFFF_FFFF_F000);
        exp_done++;
        for (int i = 0; i < 4; i++) send(13'h1FFF, 4'd13, 1'b0);
        send(13'h0000, 4'd12, 1'b1);
        wait_idle("exact");

        // backpressure: word held while fo_full, incoming tokens stall
        fo_full = 1'b1;
        exp_q.push_back(64'hD5E6_AF35_79AB_CD5E);
        exp_q.push_back(64'h6AF3_579A_BCD5_E7FF);
        exp_done++;
        for (int i = 0; i < 5; i++) send(13'h1ABC, 4'd13, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) send(13'h1ABC, 4'd13, 1'b0);
                send(13'h07FF, 4'd11, 1'b1);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_ack",  {63'd0, token_ack}, 64'd0);
                    check("stall_data", fo_data, 64'hD5E6_AF35_79AB_CD5E);
                end
                @(posedge clk);
                #1;
                fo_full = 1'b0;
            end
        join
        wait_idle("stall");

        // reset after 40 accepted bits, then a fresh word
        for (int i = 0; i < 5; i++) send(13'h00AA, 4'd8, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_wen",  {63'd0, fo_wen},    64'd0);
        check("mid_rst_ack",  {63'd0, token_ack}, 64'd0);
        check("mid_rst_done", {63'd0, done_o},    64'd0);
        check("mid_rst_data", fo_data,            64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(64'h0102_0304_0506_0708);
        for (int i = 1; i <= 8; i++) send(13'(i), 4'd8, 1'b0);
        wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
